dispatch_ctrl: RTL and testbench
================================

// Module: dispatch_ctrl
// PURPOSE
// - In-order, single-issue dispatch scheduler between the decoder and the three functional-unit
//   reservation stations: ALU, Branch and LSU.
// - Buffers one decoded instruction and steers it by FUtype to its target FU.
// - Issues only when that FU holds a free-entry credit, and back-pressures the decoder otherwise.
// PARAMETERS
// - PC_W       9   width of instruction PC
// - PAYLOAD_W  64  width of opaque decoded payload (rs1/rs2/rd/imm/ctrl bits), passed through unchanged
// - ALU_CRED   8   ALU reservation-station depth = initial/max ALU credits
// - BR_CRED    4   Branch RS depth = initial/max Branch credits
// - LSU_CRED   8   LSU RS depth = initial/max LSU credits
// PORTS
// - clk            in   1          clock, all state on rising edge
// - rst_n          in   1          asynchronous active-low reset
// - i_valid        in   1          decoder has an instruction
// - i_futype       in   2          00 ALU, 01 Branch, 10 LSU, 11 illegal
// - i_pc           in   PC_W       instruction PC
// - i_payload      in   PAYLOAD_W  decoded fields
// - o_ready        out  1          dispatch can accept this cycle
// - i_flush        in   1          kill buffered instruction (mispredict)
// - i_alu_cred     in   1          ALU RS freed one entry (1-cycle pulse)
// - i_br_cred      in   1          Branch RS freed one entry
// - i_lsu_cred     in   1          LSU RS freed one entry
// - o_alu_valid    out  1          issue to ALU RS this cycle
// - o_br_valid     out  1          issue to Branch RS this cycle
// - o_lsu_valid    out  1          issue to LSU RS this cycle
// - o_pc           out  PC_W       PC of issued instruction
// - o_payload      out  PAYLOAD_W  payload of issued instruction
// - o_illegal      out  1          1-cycle pulse: illegal FUtype entry dropped
// - o_cred_err     out  1          sticky: credit returned while counter already at max
// - o_stall_cnt    out  32         no-credit stall cycles (DISPATCH_PERF_EN only)
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - hold_v=0; credit counters = ALU_CRED / BR_CRED / LSU_CRED.
//   - o_*_valid, o_illegal and o_cred_err = 0; o_pc and o_payload = 0.
//   - o_ready = 1 once rst_n deasserts.
//   - Reset asserted mid-transfer discards the held instruction.
// - Holding register: hold_v, hold_fu, hold_pc, hold_payload.
//   - o_pc and o_payload are driven directly from hold_pc and hold_payload.
// - issue = hold_v & cred[hold_fu] != 0 & hold_fu != 11. Issue is combinational from registered state.
// - o_<fu>_valid = issue & (hold_fu == <fu>). At most one o_<fu>_valid is high per cycle.
// - hold_fu == 11 with hold_v:
//   - o_illegal = 1 that cycle; the entry is dropped (treated as drained).
//   - No credit is consumed and no o_<fu>_valid is asserted.
// - drain = issue | (hold_v & hold_fu == 11).
// - o_ready = ~hold_v | drain, giving throughput of 1 instruction per cycle when credits are present.
// - Load: on i_valid & o_ready & ~i_flush, the hold register takes i_* at the next edge.
//   - Otherwise, on drain, hold_v clears.
//   - Latency: decoder handshake at cycle N -> o_<fu>_valid at N+1 at earliest.
// - Stall: hold_v & cred==0 keeps hold_v=1, with o_pc and o_payload stable until a credit arrives.
// - Credit counter width = $clog2(max+1). Next-value rules:
//   - issue only: -1.
//   - return only: +1.
//   - both the same cycle: unchanged.
//   - return with the counter at max and no issue: the counter holds and o_cred_err is set sticky.
//   - A credit returned in cycle N is usable for issue in cycle N+1; there is no same-cycle bypass.
// - Flush: i_flush=1 clears hold_v at the next edge and blocks the same-cycle load.
//   - Any issue already asserted that cycle still completes and consumes its credit.
//   - Credit counters are not altered by flush; the RSs return credits for their flushed entries.
// - Decoder side must hold i_valid, i_futype, i_pc and i_payload stable while i_valid & ~o_ready.
// CONFIGURATION
// - DISPATCH_PERF_EN defined:
//   - o_stall_cnt is a 32-bit counter, incremented every cycle hold_v & hold_fu != 11 & cred[hold_fu] == 0.
//   - It wraps at 2^32 and is reset to 0.
// - DISPATCH_PERF_EN undefined: no counter logic; o_stall_cnt tied to 32'd0. The port is always present.
// TESTING
// - Reset, then i_valid=1 with futype 00, pc=0x010 for one cycle
//   -> o_alu_valid=1 at next cycle with o_pc=0x010; ALU credit 8->7.
// - 5 back-to-back Branch instructions, no credit return
//   -> 4 issue on consecutive cycles; the 5th stalls with o_ready=0.
//   - Then i_br_cred pulse at cycle N -> 5th issues at N+1.
// - Interleaved ALU/LSU/Branch stream with credits available
//   -> one issue per cycle, in order, each to the correct FU only.
// - i_futype=11 -> o_illegal 1-cycle pulse, no FU valid, credits unchanged, next instruction accepted.
// - Hold a stalled LSU entry and assert i_flush -> entry gone next cycle, o_ready=1, no o_lsu_valid.
// - i_alu_cred while ALU credit=8 -> o_cred_err=1 and stays set. Simultaneous issue+return -> count unchanged.
// - DISPATCH_PERF_EN: zero-credit stall of 3 cycles -> o_stall_cnt=3; macro undefined -> o_stall_cnt stays 0.

Source files
------------

// File: rtl/dispatch_ctrl.sv
// In-order single-issue dispatch: one holding register steered by FU type to ALU/Branch/LSU, credit-gated.
// Latency 1 cycle handshake->issue; o_ready drops while the held entry lacks a credit. Optional DISPATCH_PERF_EN.
module dispatch_ctrl #(
  parameter int PC_W      = 9,
  parameter int PAYLOAD_W = 64,
  parameter int ALU_CRED  = 8,
  parameter int BR_CRED   = 4,
  parameter int LSU_CRED  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  input  logic [1:0]           i_futype,
  input  logic [PC_W-1:0]      i_pc,
  input  logic [PAYLOAD_W-1:0] i_payload,
  output logic                 o_ready,
  input  logic                 i_flush,
  input  logic                 i_alu_cred,
  input  logic                 i_br_cred,
  input  logic                 i_lsu_cred,
  output logic                 o_alu_valid,
  output logic                 o_br_valid,
  output logic                 o_lsu_valid,
  output logic [PC_W-1:0]      o_pc,
  output logic [PAYLOAD_W-1:0] o_payload,
  output logic                 o_illegal,
  output logic                 o_cred_err,
  output logic [31:0]          o_stall_cnt
);

  localparam logic [1:0] FU_ALU = 2'b00;
  localparam logic [1:0] FU_BR  = 2'b01;
  localparam logic [1:0] FU_LSU = 2'b10;
  localparam logic [1:0] FU_ILL = 2'b11;

  localparam int ALU_W = $clog2(ALU_CRED + 1);
  localparam int BR_W  = $clog2(BR_CRED + 1);
  localparam int LSU_W = $clog2(LSU_CRED + 1);

  localparam logic [ALU_W-1:0] ALU_MAX = ALU_W'(ALU_CRED);
  localparam logic [BR_W-1:0]  BR_MAX  = BR_W'(BR_CRED);
  localparam logic [LSU_W-1:0] LSU_MAX = LSU_W'(LSU_CRED);

  logic                 r_hold_v;
  logic [1:0]           r_hold_fu;
  logic [PC_W-1:0]      r_hold_pc;
  logic [PAYLOAD_W-1:0] r_hold_payload;
  logic [ALU_W-1:0]     r_alu_cnt;
  logic [BR_W-1:0]      r_br_cnt;
  logic [LSU_W-1:0]     r_lsu_cnt;
  logic                 r_cred_err;

  logic w_cred_nz;
  logic w_issue;
  logic w_illegal;
  logic w_drain;
  logic w_ready;
  logic w_load;
  logic w_alu_iss;
  logic w_br_iss;
  logic w_lsu_iss;
  logic w_alu_ovf;
  logic w_br_ovf;
  logic w_lsu_ovf;

  always_comb begin
    w_cred_nz = 1'b0;
    case (r_hold_fu)
      FU_ALU:  w_cred_nz = (r_alu_cnt != '0);
      FU_BR:   w_cred_nz = (r_br_cnt  != '0);
      FU_LSU:  w_cred_nz = (r_lsu_cnt != '0);
      default: w_cred_nz = 1'b0;
    endcase
  end

  // Illegal entries drain without issuing so the decoder never deadlocks on them.
  assign w_issue   = r_hold_v & w_cred_nz & (r_hold_fu != FU_ILL);
  assign w_illegal = r_hold_v & (r_hold_fu == FU_ILL);
  assign w_drain   = w_issue | w_illegal;
  assign w_ready   = ~r_hold_v | w_drain;
  assign w_load    = i_valid & w_ready & ~i_flush;

  assign w_alu_iss = w_issue & (r_hold_fu == FU_ALU);
  assign w_br_iss  = w_issue & (r_hold_fu == FU_BR);
  assign w_lsu_iss = w_issue & (r_hold_fu == FU_LSU);

  assign o_ready     = w_ready;
  assign o_alu_valid = w_alu_iss;
  assign o_br_valid  = w_br_iss;
  assign o_lsu_valid = w_lsu_iss;
  assign o_pc        = r_hold_pc;
  assign o_payload   = r_hold_payload;
  assign o_illegal   = w_illegal;
  assign o_cred_err  = r_cred_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_v       <= 1'b0;
      r_hold_fu      <= FU_ALU;
      r_hold_pc      <= '0;
      r_hold_payload <= '0;
    end else if (w_load) begin
      r_hold_v       <= 1'b1;
      r_hold_fu      <= i_futype;
      r_hold_pc      <= i_pc;
      r_hold_payload <= i_payload;
    end else if (w_drain | i_flush) begin
      r_hold_v <= 1'b0;
    end
  end

  // A return with no issue at a full counter is a protocol error from the RS.
  assign w_alu_ovf = i_alu_cred & ~w_alu_iss & (r_alu_cnt == ALU_MAX);
  assign w_br_ovf  = i_br_cred  & ~w_br_iss  & (r_br_cnt  == BR_MAX);
  assign w_lsu_ovf = i_lsu_cred & ~w_lsu_iss & (r_lsu_cnt == LSU_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_cnt <= ALU_MAX;
    end else if (w_alu_iss & ~i_alu_cred) begin
      r_alu_cnt <= r_alu_cnt - 1'b1;
    end else if (i_alu_cred & ~w_alu_iss & ~w_alu_ovf) begin
      r_alu_cnt <= r_alu_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt <= BR_MAX;
    end else if (w_br_iss & ~i_br_cred) begin
      r_br_cnt <= r_br_cnt - 1'b1;
    end else if (i_br_cred & ~w_br_iss & ~w_br_ovf) begin
      r_br_cnt <= r_br_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lsu_cnt <= LSU_MAX;
    end else if (w_lsu_iss & ~i_lsu_cred) begin
      r_lsu_cnt <= r_lsu_cnt - 1'b1;
    end else if (i_lsu_cred & ~w_lsu_iss & ~w_lsu_ovf) begin
      r_lsu_cnt <= r_lsu_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cred_err <= 1'b0;
    end else if (w_alu_ovf | w_br_ovf | w_lsu_ovf) begin
      r_cred_err <= 1'b1;
    end
  end

`ifdef DISPATCH_PERF_EN
  logic        w_stall;
  logic [31:0] r_stall_cnt;

  assign w_stall = r_hold_v & (r_hold_fu != FU_ILL) & ~w_cred_nz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: inputs driven and outputs sampled 1ns after each rising edge.
module tb_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [1:0]  i_futype;
  logic [8:0]  i_pc;
  logic [63:0] i_payload;
  logic        o_ready;
  logic        i_flush;
  logic        i_alu_cred;
  logic        i_br_cred;
  logic        i_lsu_cred;
  logic        o_alu_valid;
  logic        o_br_valid;
  logic        o_lsu_valid;
  logic [8:0]  o_pc;
  logic [63:0] o_payload;
  logic        o_illegal;
  logic        o_cred_err;
  logic [31:0] o_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dispatch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_futype(i_futype), .i_pc(i_pc), .i_payload(i_payload),
    .o_ready(o_ready), .i_flush(i_flush),
    .i_alu_cred(i_alu_cred), .i_br_cred(i_br_cred), .i_lsu_cred(i_lsu_cred),
    .o_alu_valid(o_alu_valid), .o_br_valid(o_br_valid), .o_lsu_valid(o_lsu_valid),
    .o_pc(o_pc), .o_payload(o_payload), .o_illegal(o_illegal),
    .o_cred_err(o_cred_err), .o_stall_cnt(o_stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] fu, input logic [8:0] pc);
    i_valid   = v;
    i_futype  = fu;
    i_pc      = pc;
    i_payload = {55'h0ABCDE, pc};
  endtask

  task automatic chk_fu(input string tag, input logic a, input logic b, input logic l);
    chk({tag, "_alu"}, o_alu_valid, a);
    chk({tag, "_br"},  o_br_valid,  b);
    chk({tag, "_lsu"}, o_lsu_valid, l);
  endtask

  logic [1:0] mix_fu [5];
  logic [31:0] exp_stall;

  initial begin
    rst_n = 1'b0;
    i_flush = 1'b0; i_alu_cred = 1'b0; i_br_cred = 1'b0; i_lsu_cred = 1'b0;
    drive(1'b0, 2'b00, 9'h0);
    #12;
    chk("rst_ready", o_ready, 1'b1);
    chk_fu("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_pc", o_pc, 9'h0);
    chk("rst_payload", o_payload, 64'h0);
    chk("rst_illegal", o_illegal, 1'b0);
    chk("rst_cred_err", o_cred_err, 1'b0);
    chk("rst_stall", o_stall_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single ALU instruction
    drive(1'b1, 2'b00, 9'h010);
    step();
    chk_fu("alu1", 1'b1, 1'b0, 1'b0);
    chk("alu1_pc", o_pc, 9'h010);
    chk("alu1_payload", o_payload, {55'h0ABCDE, 9'h010});
    drive(1'b0, 2'b00, 9'h0);
    step();
    chk("alu1_done", o_alu_valid, 1'b0);

    // ALU now at 7: first return reaches 8 cleanly, second overflows
    i_alu_cred = 1'b1;
    step();
    chk("cred_ret_ok", o_cred_err, 1'b0);
    step();
    chk("cred_err_set", o_cred_err, 1'b1);
    i_alu_cred = 1'b0;
    step();
    chk("cred_err_sticky", o_cred_err, 1'b1);

    // Five branches against four credits
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'b01, 9'h100 + 9'(k));
      step();
      chk_fu("br_issue", 1'b0, 1'b1, 1'b0);
      chk("br_issue_pc", o_pc, 9'h100 + 9'(k));
    end
    drive(1'b1, 2'b01, 9'h104);
    step();
    chk("br5_stall_valid", o_br_valid, 1'b0);
    chk("br5_stall_ready", o_ready, 1'b0);
    drive(1'b0, 2'b00, 9'h0);
    step();
    step();
    chk("br5_still_stalled", o_br_valid, 1'b0);
    chk("br5_pc_stable", o_pc, 9'h104);
    i_br_cred = 1'b1;
    step();
    i_br_cred = 1'b0;
    chk("br5_issue", o_br_valid, 1'b1);
    chk("br5_issue_pc", o_pc, 9'h104);
`ifdef DISPATCH_PERF_EN
    exp_stall = 32'd3;
`else
    exp_stall = 32'd0;
`endif
    chk("stall_cnt", o_stall_cnt, exp_stall);
    step();
    chk("br5_done", o_br_valid, 1'b0);
    chk("br5_ready", o_ready, 1'b1);

    // Restore two branch credits, then an interleaved stream
    i_br_cred = 1'b1;
    step();
    step();
    i_br_cred = 1'b0;
    mix_fu[0] = 2'b00; mix_fu[1] = 2'b10; mix_fu[2] = 2'b01; mix_fu[3] = 2'b00; mix_fu[4] = 2'b10;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, mix_fu[k], 9'h200 + 9'(k));
      step();
      chk_fu("mix", mix_fu[k] == 2'b00, mix_fu[k] == 2'b01, mix_fu[k] == 2'b10);
      chk("mix_pc", o_pc, 9'h200 + 9'(k));
      chk("mix_ready", o_ready, 1'b1);
    end

    // Illegal type is dropped, next instruction follows immediately
    drive(1'b1, 2'b11, 9'h300);
    step();
    chk("ill_pulse", o_illegal, 1'b1);
    chk_fu("ill", 1'b0, 1'b0, 1'b0);
    chk("ill_ready", o_ready, 1'b1);
    drive(1'b1, 2'b00, 9'h301);
    step();
    chk("ill_clear", o_illegal, 1'b0);
    chk("ill_next_alu", o_alu_valid, 1'b1);
    chk("ill_next_pc", o_pc, 9'h301);

    // Branch credit is 1: issue with simultaneous return keeps it at 1
    drive(1'b1, 2'b01, 9'h400);
    step();
    chk("sim_br0", o_br_valid, 1'b1);
    drive(1'b1, 2'b01, 9'h401);
    i_br_cred = 1'b1;
    step();
    i_br_cred = 1'b0;
    chk("sim_br1", o_br_valid, 1'b1);
    chk("sim_br1_pc", o_pc, 9'h401);
    drive(1'b1, 2'b01, 9'h402);
    step();
    chk("sim_br2_stall", o_br_valid, 1'b0);
    chk("sim_br2_ready", o_ready, 1'b0);
    drive(1'b0, 2'b00, 9'h0);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("br_flush_ready", o_ready, 1'b1);
    chk("br_flush_valid", o_br_valid, 1'b0);

    // LSU has 6 credits left; seventh stalls and is flushed
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 2'b10, 9'h500 + 9'(k));
      step();
      chk("lsu_run", o_lsu_valid, k < 6);
    end
    chk("lsu_stall_ready", o_ready, 1'b0);
    drive(1'b0, 2'b00, 9'h0);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("lsu_flush_valid", o_lsu_valid, 1'b0);
    chk("lsu_flush_ready", o_ready, 1'b1);

    // Flush blocks a same-cycle load
    drive(1'b1, 2'b00, 9'h600);
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    drive(1'b0, 2'b00, 9'h0);
    chk("flush_blocks_load", o_alu_valid, 1'b0);

    // Stalled LSU entry discarded by async reset
    drive(1'b1, 2'b10, 9'h1AB);
    step();
    drive(1'b0, 2'b00, 9'h0);
    chk("pre_rst_stall", o_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", o_ready, 1'b1);
    chk("arst_pc", o_pc, 9'h0);
    chk("arst_lsu", o_lsu_valid, 1'b0);
    chk("arst_cred_err", o_cred_err, 1'b0);
    chk("arst_stall", o_stall_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
